// File: rtl/riscv_uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter.
// Contents:
//   arb_state_e - bus FSM states (idle, read setup/access, write setup/access)
//   A_RD, A_WR  - register offsets of the UART status and TX data words
//   DATA_WIDTH  - width of one requester byte
//   ASCII_LF    - line-feed byte that ends a locked console line
package riscv_uart_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdSetup,
        StRdAccess,
        StWrSetup,
        StWrAccess
    } arb_state_e;

    localparam logic [11:0] A_RD = 12'h000;
    localparam logic [11:0] A_WR = 12'h004;

    localparam int unsigned DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - last granted index; the search starts at ptr+1 and wraps
//   force_en  - when set, only force_idx may be granted
//   force_idx - the only index eligible while force_en is set
//   grant     - one-hot grant (all zero when nothing is granted)
//   grant_idx - index of the granted requester (0 when nothing is granted)
module riscv_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            force_en,
    input  logic [IDW-1:0]  force_idx,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (force_en) begin
            if (req[force_idx]) begin
                grant[force_idx] = 1'b1;
                grant_idx        = force_idx;
            end
        end else begin
            // First requester found after ptr, wrapping modulo NREQ.
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IDW'((32'(ptr) + k) % NREQ);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_uart_tx_arbiter.sv
// Shares the UART TX data register between NREQ byte-stream requesters.
// For each granted byte it polls the status word (rdata[0] = TX ready) until
// ready, then writes the byte to the data word, acting as the bus master.
// Optional feature macro: RISCV_UART_ARB_LINE_LOCK_EN - hold the grant for a
// whole text line (until 0x0A) or until the owner idles LOCK_TIMEOUT cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/data    - per-requester byte valid and byte (requester i at [8i+7:8i])
//   req_ready         - one-cycle pulse when the requester's byte is written
//   sel/enable/write  - bus select, access phase, direction
//   addr/wdata/rdata  - bus address, write data, read data
//   grant_id          - current or last granted requester
//   busy              - FSM not idle
module riscv_uart_tx_arbiter
    import riscv_uart_arb_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NREQ         = 2,
    parameter logic [XLEN-1:0] BASE_ADDR    = '0,
    parameter int unsigned     LOCK_TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       sel,
    output logic                       enable,
    output logic                       write,
    output logic [XLEN-1:0]            addr,
    output logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;

    logic                  sel_q, sel_d;
    logic                  enable_q, enable_d;
    logic                  write_q, write_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [NREQ-1:0]       ready_q, ready_d;
    logic                  busy_q;

    logic [NREQ-1:0]       arb_grant;
    logic [IDW-1:0]        arb_idx;
    logic                  force_en;
    logic [IDW-1:0]        force_idx;

    logic [DATA_WIDTH-1:0] req_bytes [NREQ];
    logic                  unused_rdata;

    assign unused_rdata = ^rdata[XLEN-1:1];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    riscv_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .force_en  (force_en),
        .force_idx (force_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef RISCV_UART_ARB_LINE_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_TIMEOUT + 1);

    logic            lock_q, lock_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

    assign force_en  = lock_q;
    assign force_idx = owner_q;

    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        if (state_q == StWrAccess) begin
            // A line feed ends the line; any other byte (re)opens the lock.
            lock_d     = (byte_q != ASCII_LF);
            owner_d    = gnt_q;
            idle_cnt_d = '0;
        end else if (state_q == StIdle && lock_q) begin
            if (req_valid[owner_q]) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                // Owner silent for LOCK_TIMEOUT idle cycles: release. The rr
                // pointer already points at the owner, so rotation resumes there.
                lock_d     = 1'b0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            owner_q    <= '0;
            idle_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign force_en  = 1'b0;
    assign force_idx = '0;
`endif

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        byte_d   = byte_q;
        unique case (state_q)
            StIdle: begin
                if (|arb_grant) begin
                    // Byte captured here; later drops of valid cannot cancel it.
                    byte_d  = req_bytes[arb_idx];
                    gnt_d   = arb_idx;
                    state_d = StRdSetup;
                end
            end
            StRdSetup:  state_d = StRdAccess;
            StRdAccess: state_d = rdata[0] ? StWrSetup : StRdSetup;
            StWrSetup:  state_d = StWrAccess;
            StWrAccess: begin
                rr_ptr_d = gnt_q;
                state_d  = StIdle;
            end
            default:    state_d = StIdle;
        endcase
    end

    // Registered bus outputs decoded from the next state, so they line up with
    // the state they describe.
    always_comb begin
        sel_d    = 1'b0;
        enable_d = 1'b0;
        write_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready_d  = '0;
        case (state_d)
            StRdSetup: begin
                sel_d  = 1'b1;
                addr_d = BASE_ADDR + XLEN'(A_RD);
            end
            StRdAccess: begin
                sel_d    = 1'b1;
                enable_d = 1'b1;
                addr_d   = BASE_ADDR + XLEN'(A_RD);
            end
            StWrSetup: begin
                sel_d   = 1'b1;
                write_d = 1'b1;
                addr_d  = BASE_ADDR + XLEN'(A_WR);
                wdata_d = {{(XLEN-DATA_WIDTH){1'b0}}, byte_d};
            end
            StWrAccess: begin
                sel_d          = 1'b1;
                enable_d       = 1'b1;
                write_d        = 1'b1;
                addr_d         = BASE_ADDR + XLEN'(A_WR);
                wdata_d        = {{(XLEN-DATA_WIDTH){1'b0}}, byte_d};
                ready_d[gnt_d] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= IDW'(NREQ - 1);
            gnt_q    <= '0;
            byte_q   <= '0;
            sel_q    <= 1'b0;
            enable_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            byte_q   <= byte_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign sel       = sel_q;
    assign enable    = enable_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign req_ready = ready_q;
    assign grant_id  = gnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_riscv_uart_tx_arbiter.sv
// Scoreboard bench for riscv_uart_tx_arbiter (NREQ=2). Stimulus pushes the
// expected write sequence; a negedge monitor pops and compares on each write
// access. Line-lock scenarios are built only with RISCV_UART_ARB_LINE_LOCK_EN.
module tb_riscv_uart_tx_arbiter;

    localparam int unsigned     XLEN = 32;
    localparam int unsigned     NREQ = 2;
    localparam logic [XLEN-1:0] BASE = 32'h4000_0000;
    localparam int unsigned     LT   = 8;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [15:0]     req_data;
    logic [NREQ-1:0] req_ready;
    logic            sel, enable, write;
    logic [XLEN-1:0] addr, wdata, rdata;
    logic            grant_id;
    logic            busy;

    riscv_uart_tx_arbiter #(
        .XLEN         (XLEN),
        .NREQ         (NREQ),
        .BASE_ADDR    (BASE),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sel       (sel),
        .enable    (enable),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         id;
        int         polls;
        int         rdy_cyc;  // -1: cycle not checked
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src0[$];
    logic [7:0] src1[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fail_polls = 0;
    int         polls_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int id, input int polls, input int rc);
        exp_t e;
        e.data    = d;
        e.id      = id;
        e.polls   = polls;
        e.rdy_cyc = rc;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (1) begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, (n >= 300), 0);
        check({name, "_exp_left"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Requester model: hold valid/data until ready, then advance.
    initial forever begin
        @(negedge clk);
        if (req_ready[0] && src0.size() > 0) void'(src0.pop_front());
        if (req_ready[1] && src1.size() > 0) void'(src1.pop_front());
        req_valid[0]   = (src0.size() > 0);
        req_valid[1]   = (src1.size() > 0);
        req_data[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
        req_data[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
    end

    // UART status responder: answer "not ready" fail_polls times, then ready.
    initial forever begin
        @(negedge clk);
        if (sel && enable && !write) begin
            if (fail_polls > 0) begin
                rdata = 32'h0;
                fail_polls--;
            end else begin
                rdata = 32'h1;
            end
        end else begin
            rdata = 32'h0;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            polls_seen = 0;
        end else begin
            if (sel && enable && !write) begin
                polls_seen++;
                check("rd_addr", addr, BASE);
            end
            if (sel && enable && write) begin
                check("unexpected_write", (exp_q.size() == 0), 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wdata", wdata, {24'h0, e.data});
                    check("wr_addr", addr, BASE + 32'h4);
                    check("grant_id", grant_id, e.id);
                    check("req_ready", req_ready, 32'(1 << e.id));
                    check("poll_count", polls_seen, e.polls);
                    if (e.rdy_cyc >= 0) check("ready_cycle", cyc, e.rdy_cyc);
                end
                polls_seen = 0;
            end else begin
                check("ready_outside_write", req_ready, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic found;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rdata     = '0;
        repeat (3) @(negedge clk);
        // Reset state.
        check("rst_sel", sel, 0);
        check("rst_enable", enable, 0);
        check("rst_write", write, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, UART immediately ready.
        @(posedge clk); #1;
        t0 = cyc;
        src0.push_back(8'h41);
        push_exp(8'h41, 0, 1, t0 + 4);
        wait_cyc(t0 + 1);
        check("t1_c1_sel", {sel, enable, write}, 3'b100);
        check("t1_c1_addr", addr, BASE);
        wait_cyc(t0 + 2);
        check("t1_c2_access", {sel, enable, write}, 3'b110);
        wait_cyc(t0 + 3);
        check("t1_c3_wsetup", {sel, enable, write}, 3'b101);
        wait_cyc(t0 + 5);
        check("t1_c5_busy", busy, 0);
        check("t1_c5_bus", {sel, enable, write}, 3'b000);
        check("t1_c5_addr_hold", addr, BASE + 32'h4);
        check("t1_c5_wdata_hold", wdata, 32'h41);
        drain("t1");

        // Three failed polls.
        @(posedge clk); #1;
        t0 = cyc;
        fail_polls = 3;
        src0.push_back(8'h42);
        push_exp(8'h42, 0, 4, t0 + 10);
        drain("t2");

        // Reset in WR_SETUP discards the byte; it is re-sent after release.
        do_reset();
        @(posedge clk); #1;
        src0.push_back(8'h5A);
        push_exp(8'h5A, 0, 1, -1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (sel && write && !enable) found = 1'b1;
        end
        check("t6_reached_wsetup", found, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_bus_drop", {sel, enable, write}, 3'b000);
        check("t6_no_ready", req_ready, 0);
        check("t6_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_restart_rdsetup", {sel, enable, write}, 3'b100);
        check("t6_restart_addr", addr, BASE);
        drain("t6");

        // Two always-valid requesters alternate.
        do_reset();
        @(posedge clk); #1;
        src0.push_back(8'hA0);
        src0.push_back(8'hA0);
        src1.push_back(8'hB0);
        src1.push_back(8'hB0);
        push_exp(8'hA0, 0, 1, -1);
        push_exp(8'hB0, 1, 1, -1);
        push_exp(8'hA0, 0, 1, -1);
        push_exp(8'hB0, 1, 1, -1);
        drain("t3");

`ifdef RISCV_UART_ARB_LINE_LOCK_EN
        // Line lock holds requester 0 until its line feed.
        do_reset();
        @(posedge clk); #1;
        t0 = cyc;
        src0.push_back(8'h41);
        src0.push_back(8'h42);
        src0.push_back(8'h0A);
        src1.push_back(8'h78);
        push_exp(8'h41, 0, 1, t0 + 4);
        push_exp(8'h42, 0, 1, t0 + 9);
        push_exp(8'h0A, 0, 1, t0 + 14);
        push_exp(8'h78, 1, 1, t0 + 19);
        drain("t4");

        // Owner goes quiet: lock released after LT idle cycles.
        do_reset();
        @(posedge clk); #1;
        t0 = cyc;
        src0.push_back(8'h41);
        src1.push_back(8'h79);
        push_exp(8'h41, 0, 1, t0 + 4);
        push_exp(8'h79, 1, 1, t0 + 9 + LT);
        drain("t5");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
